// File: rtl/cnn_pkg.sv
// Shared CNN datapath helpers: width arithmetic, signed typedefs and a saturating add.
// Latency: n/a (package only). Backpressure: n/a.
// Contents: clog2(), SUM_W(), sat_add(); operand_t/product_t/acc_t at the default widths.
package cnn_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 24;

   typedef logic signed [DEF_DATA_W-1:0]   operand_t;
   typedef logic signed [2*DEF_DATA_W-1:0] product_t;
   typedef logic signed [DEF_ACC_W-1:0]    acc_t;

   // Wide carrier for the saturating add; any accumulator narrower than 63 bits
   // can be summed here without the intermediate itself overflowing.
   typedef logic signed [63:0] wide_t;

   typedef struct packed {
      logic  ovf;
      wide_t val;
   } sat_res_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < value) begin
         v = v * 2;
         r = r + 1;
      end
      return r;
   endfunction

   // Width of the registered lane sum: one product plus growth for the adder tree.
   function automatic int SUM_W(input int data_w, input int lanes);
      return 2 * data_w + clog2(lanes);
   endfunction

   // x + y clamped to the signed range of a w-bit value; ovf flags a clamp.
   function automatic sat_res_t sat_add(input wide_t x, input wide_t y, input int w);
      wide_t    full;
      wide_t    hi;
      wide_t    lo;
      sat_res_t r;
      full  = x + y;
      hi    = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo    = -hi - wide_t'(1);
      r.ovf = 1'b0;
      r.val = full;
      if (full > hi) begin
         r.ovf = 1'b1;
         r.val = hi;
      end else if (full < lo) begin
         r.ovf = 1'b1;
         r.val = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// LANES signed multipliers (S1) feeding a registered sign-extended lane sum (S2).
// Latency: 2 cycles from accept to sum/sum_valid. Backpressure: all registers hold while en = 0.
// Ports: clk, rst (async high), en (pipeline advance), clr (flush valids), in_valid, a, b -> sum, sum_valid.
module mac_lane_tree
   import cnn_pkg::*;
#(
   parameter int  DATA_W = 8,
   parameter int  LANES  = 4,
   localparam int SW     = SUM_W(DATA_W, LANES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clr,
   input  logic                     in_valid,
   input  logic [LANES*DATA_W-1:0]  a,
   input  logic [LANES*DATA_W-1:0]  b,
   output logic signed [SW-1:0]     sum,
   output logic                     sum_valid
);

   logic signed [2*DATA_W-1:0] prod_d [LANES];
   logic signed [2*DATA_W-1:0] prod_q [LANES];
   logic                       v1;
   logic signed [SW-1:0]       sum_d;

   // Operands are sign-extended to the product width first, so the product
   // is exact (|-2^(N-1) * -2^(N-1)| still fits in 2N signed bits).
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod_d[i] = (2*DATA_W)'($signed(a[i*DATA_W +: DATA_W]))
                   * (2*DATA_W)'($signed(b[i*DATA_W +: DATA_W]));
      end
   end

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_d = sum_d + SW'(prod_q[i]);
      end
   end

   // clr acts even while stalled: it only kills valids, it never creates data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         sum_valid <= 1'b0;
         sum       <= '0;
         for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= '0;
         end
      end else if (clr) begin
         v1        <= 1'b0;
         sum_valid <= 1'b0;
      end else if (en) begin
         v1        <= in_valid;
         prod_q    <= prod_d;
         sum_valid <= v1;
         sum       <= sum_d;
      end
   end

endmodule

// File: rtl/mac_lane_acc.sv
// Multi-lane signed MAC: accumulates KLEN lane-sum beats into one ACC_W result.
// Latency: 3 cycles from the last tap's accept to out_valid. Backpressure: in_ready = !out_valid || out_ready; a stall freezes every stage.
// Ports: clk, rst (async high), clr (sync flush), in_valid/in_ready/a/b in, out_valid/out_ready/y/y_ovf out.
// Build option MAC_SATURATE_EN: clamp each accumulation step and report clamps on y_ovf; otherwise wrap and tie y_ovf low.
module mac_lane_acc
   import cnn_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int LANES  = 4,
   parameter int KLEN   = 9
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*DATA_W-1:0]    a,
   input  logic [LANES*DATA_W-1:0]    b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [ACC_W-1:0]    y,
   output logic                       y_ovf
);

   localparam int SW    = SUM_W(DATA_W, LANES);
   localparam int CNT_W = (clog2(KLEN) < 1) ? 1 : clog2(KLEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(KLEN - 1);

   logic                    adv;
   logic signed [SW-1:0]    sum2;
   logic                    v2;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        tap_cnt;
   logic signed [ACC_W-1:0] step_val;

   // The only combinational in->out path: out_ready -> in_ready.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   mac_lane_tree #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
   ) u_tree (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .clr       (clr),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .sum       (sum2),
      .sum_valid (v2)
   );

`ifdef MAC_SATURATE_EN
   sat_res_t step_r;
   logic     step_ovf;
   logic     ovf_sticky;

   always_comb begin
      step_r   = sat_add(wide_t'(acc), wide_t'(sum2), ACC_W);
      step_val = step_r.val[ACC_W-1:0];
      step_ovf = step_r.ovf;
   end
`else
   assign step_val = acc + ACC_W'(sum2);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         tap_cnt   <= '0;
         out_valid <= 1'b0;
         y         <= '0;
         y_ovf     <= 1'b0;
`ifdef MAC_SATURATE_EN
         ovf_sticky <= 1'b0;
`endif
      end else begin
         // Output register: load on the last tap, otherwise drop valid once
         // consumed. A held result (adv = 0) is untouched, including under clr.
         if (adv) begin
            if (!clr && v2 && tap_cnt == LAST) begin
               out_valid <= 1'b1;
               y         <= step_val;
`ifdef MAC_SATURATE_EN
               y_ovf     <= ovf_sticky | step_ovf;
`else
               y_ovf     <= 1'b0;
`endif
            end else begin
               out_valid <= 1'b0;
            end
         end

         if (clr) begin
            acc     <= '0;
            tap_cnt <= '0;
`ifdef MAC_SATURATE_EN
            ovf_sticky <= 1'b0;
`endif
         end else if (adv && v2) begin
            if (tap_cnt == LAST) begin
               // Next window starts immediately from zero.
               acc     <= '0;
               tap_cnt <= '0;
`ifdef MAC_SATURATE_EN
               ovf_sticky <= 1'b0;
`endif
            end else begin
               acc     <= step_val;
               tap_cnt <= tap_cnt + CNT_W'(1);
`ifdef MAC_SATURATE_EN
               ovf_sticky <= ovf_sticky | step_ovf;
`endif
            end
         end
      end
   end

endmodule
